// File: rtl/baud_gen_prog.sv
// Programmable fractional baud-rate generator.
// Produces an oversample tick whose period is D or D+1 cycles, chosen so that
// the average period is D + frac/2^NB_FRAC. A bit tick fires once every
// OVERSAMPLE oversample ticks. A new divisor is staged in a pending register
// and switched in at a period boundary, or immediately while counting is
// paused. The bit phase carries across a divisor change.
module baud_gen_prog #(
    parameter int NB_DIV       = 16,
    parameter int NB_FRAC      = 4,
    parameter int OVERSAMPLE   = 16,
    parameter int DEFAULT_DIV  = 163,
    parameter int DEFAULT_FRAC = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_enable,
    input  logic [NB_DIV-1:0]          i_div_int,
    input  logic [NB_FRAC-1:0]         i_div_frac,
    input  logic                       i_load,
    output logic                       o_tick,
    output logic                       o_bit_tick,
    output logic                       o_pending,
    output logic [NB_DIV+NB_FRAC-1:0]  o_div_active
);

    localparam int NB_ACT = NB_DIV + NB_FRAC;
    localparam int NB_SUB = $clog2(OVERSAMPLE);
    localparam logic [NB_SUB-1:0] SUB_LAST     = NB_SUB'(OVERSAMPLE - 1);
    localparam logic [NB_ACT-1:0] ACTIVE_RESET = {NB_DIV'(DEFAULT_DIV), NB_FRAC'(DEFAULT_FRAC)};

    // Architectural state
    logic [NB_DIV-1:0]  r_cnt;
    logic [NB_FRAC-1:0] r_acc;
    logic               r_ext;
    logic [NB_SUB-1:0]  r_sub;
    logic [NB_ACT-1:0]  r_active;
    logic [NB_ACT-1:0]  r_pend;
    logic               r_pend_flag;
    logic               r_tick;
    logic               r_bit_tick;

    // Decoded divisor and period control
    logic [NB_DIV-1:0]  w_act_int;
    logic [NB_FRAC-1:0] w_act_frac;
    logic [NB_DIV-1:0]  w_div_eff;
    logic [NB_DIV:0]    w_term;
    logic [NB_FRAC:0]   w_frac_sum;
    logic               w_wrap;
    logic               w_apply;
    logic               w_sub_last;

    // Next-state values
    logic [NB_DIV-1:0]  w_cnt_next;
    logic [NB_FRAC-1:0] w_acc_next;
    logic               w_ext_next;
    logic [NB_SUB-1:0]  w_sub_next;
    logic [NB_ACT-1:0]  w_active_next;
    logic [NB_ACT-1:0]  w_pend_next;
    logic               w_pend_flag_next;

    assign w_act_int  = r_active[NB_ACT-1:NB_FRAC];
    assign w_act_frac = r_active[NB_FRAC-1:0];

    // A programmed integer divisor of zero is treated as one.
    assign w_div_eff  = (w_act_int == '0) ? NB_DIV'(1) : w_act_int;

    // Terminal count is one wider than the counter so D-1+ext never overflows.
    assign w_term     = ({1'b0, w_div_eff} - (NB_DIV+1)'(1)) + {{NB_DIV{1'b0}}, r_ext};
    assign w_wrap     = i_enable && ({1'b0, r_cnt} == w_term);
    assign w_frac_sum = {1'b0, r_acc} + {1'b0, w_act_frac};
    assign w_sub_last = (r_sub == SUB_LAST);

    // A staged divisor switches in at a period boundary, or at once while paused.
    assign w_apply    = r_pend_flag && (w_wrap || !i_enable);

    // Next-state logic for counters, divisor registers and the pending flag
    always_comb begin
        w_cnt_next       = r_cnt;
        w_acc_next       = r_acc;
        w_ext_next       = r_ext;
        w_sub_next       = r_sub;
        w_active_next    = r_active;
        w_pend_next      = r_pend;
        w_pend_flag_next = r_pend_flag;

        if (w_apply) begin
            // Fresh start of the period with the new divisor; fraction history dropped.
            w_active_next = r_pend;
            w_cnt_next    = '0;
            w_acc_next    = '0;
            w_ext_next    = 1'b0;
        end else if (w_wrap) begin
            // Carry out of the fraction accumulator stretches the next period by one.
            w_cnt_next = '0;
            w_acc_next = w_frac_sum[NB_FRAC-1:0];
            w_ext_next = w_frac_sum[NB_FRAC];
        end else if (i_enable) begin
            w_cnt_next = r_cnt + NB_DIV'(1);
        end

        // Bit phase advances on every period end, including one where a new divisor lands.
        if (w_wrap) begin
            w_sub_next = w_sub_last ? '0 : r_sub + NB_SUB'(1);
        end

        // A load in the same cycle as an apply stays pending for the next apply point.
        if (i_load) begin
            w_pend_next      = {i_div_int, i_div_frac};
            w_pend_flag_next = 1'b1;
        end else if (w_apply) begin
            w_pend_flag_next = 1'b0;
        end
    end

    // State and registered tick outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt       <= '0;
            r_acc       <= '0;
            r_ext       <= 1'b0;
            r_sub       <= '0;
            r_active    <= ACTIVE_RESET;
            r_pend      <= '0;
            r_pend_flag <= 1'b0;
            r_tick      <= 1'b0;
            r_bit_tick  <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_next;
            r_acc       <= w_acc_next;
            r_ext       <= w_ext_next;
            r_sub       <= w_sub_next;
            r_active    <= w_active_next;
            r_pend      <= w_pend_next;
            r_pend_flag <= w_pend_flag_next;
            r_tick      <= w_wrap;
            r_bit_tick  <= w_wrap && w_sub_last;
        end
    end

    assign o_tick       = r_tick;
    assign o_bit_tick   = r_bit_tick;
    assign o_pending    = r_pend_flag;
    assign o_div_active = r_active;

endmodule

// File: tb/tb_baud_gen_prog.sv
// Testbench for baud_gen_prog: a period-countdown model of the generator is
// compared against the DUT every cycle, while directed scenarios measure tick
// spacing and latencies against hand-computed values.
module tb_baud_gen_prog;

    localparam int NB_DIV   = 16;
    localparam int NB_FRAC  = 4;
    localparam int OS       = 16;
    localparam int DEF_DIV  = 163;
    localparam int DEF_FRAC = 0;
    localparam int FR       = 1 << NB_FRAC;

    logic                      clk = 1'b0;
    logic                      reset;
    logic                      enable;
    logic [NB_DIV-1:0]         div_int;
    logic [NB_FRAC-1:0]        div_frac;
    logic                      load;
    logic                      tick;
    logic                      bit_tick;
    logic                      pending;
    logic [NB_DIV+NB_FRAC-1:0] div_active;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    baud_gen_prog #(
        .NB_DIV      (NB_DIV),
        .NB_FRAC     (NB_FRAC),
        .OVERSAMPLE  (OS),
        .DEFAULT_DIV (DEF_DIV),
        .DEFAULT_FRAC(DEF_FRAC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .i_enable    (enable),
        .i_div_int   (div_int),
        .i_div_frac  (div_frac),
        .i_load      (load),
        .o_tick      (tick),
        .o_bit_tick  (bit_tick),
        .o_pending   (pending),
        .o_div_active(div_active)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each period is tracked as a countdown of remaining cycles; the period
    // length is D plus one whenever the running fraction sum crosses a whole cycle.
    int m_valid = 0;
    int m_int, m_frac, m_left, m_phase, m_ticks;
    int m_pflag, m_pint, m_pfrac;
    int exp_tick, exp_bit;
    int m_d, m_wrap, m_apply, m_carry;

    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            m_valid  = 1;
            m_int    = DEF_DIV;
            m_frac   = DEF_FRAC;
            m_left   = (DEF_DIV == 0) ? 1 : DEF_DIV;
            m_phase  = 0;
            m_ticks  = 0;
            m_pflag  = 0;
            m_pint   = 0;
            m_pfrac  = 0;
            exp_tick = 0;
            exp_bit  = 0;
        end else if (m_valid != 0) begin
            m_d      = (m_int == 0) ? 1 : m_int;
            m_wrap   = (enable && m_left == 1) ? 1 : 0;
            exp_tick = m_wrap;
            exp_bit  = (m_wrap != 0 && m_ticks == OS - 1) ? 1 : 0;
            if (m_wrap != 0) m_ticks = (m_ticks + 1) % OS;
            m_apply  = (m_pflag != 0 && (m_wrap != 0 || !enable)) ? 1 : 0;
            if (m_apply != 0) begin
                m_int   = m_pint;
                m_frac  = m_pfrac;
                m_phase = 0;
                m_left  = (m_int == 0) ? 1 : m_int;
            end else if (m_wrap != 0) begin
                m_phase = m_phase + m_frac;
                m_carry = (m_phase >= FR) ? 1 : 0;
                m_phase = m_phase % FR;
                m_left  = m_d + m_carry;
            end else if (enable) begin
                m_left = m_left - 1;
            end
            if (load) begin
                m_pint  = int'(div_int);
                m_pfrac = int'(div_frac);
                m_pflag = 1;
            end else if (m_apply != 0) begin
                m_pflag = 0;
            end
        end
    end

    // Cycle-by-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (m_valid != 0) begin
            chk("o_tick", int'(tick), exp_tick);
            chk("o_bit_tick", int'(bit_tick), exp_bit);
            chk("o_pending", int'(pending), m_pflag);
            chk("o_div_active", int'(div_active), (m_int << NB_FRAC) | m_frac);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_tick(input int limit, input string name, output int n);
        n = 0;
        while (1) begin
            @(negedge clk);
            n++;
            if (tick) break;
            if (n >= limit) begin
                checks++;
                errors++;
                $display("FAIL %s: no o_tick within %0d cycles", name, limit);
                break;
            end
        end
    endtask

    task automatic wait_bit(input int limit, input string name, output int n);
        n = 0;
        while (1) begin
            @(negedge clk);
            n++;
            if (bit_tick) break;
            if (n >= limit) begin
                checks++;
                errors++;
                $display("FAIL %s: no o_bit_tick within %0d cycles", name, limit);
                break;
            end
        end
    endtask

    task automatic do_load(input int di, input int df);
        load     = 1'b1;
        div_int  = NB_DIV'(di);
        div_frac = NB_FRAC'(df);
        $display("load int=%0d frac=%0d at cycle %0d", di, df, cyc);
        @(negedge clk);
        load = 1'b0;
    endtask

    int n, n2, sum, cnt11, ticks_seen;
    int per [0:40];

    initial begin
        reset    = 1'b1;
        enable   = 1'b0;
        load     = 1'b0;
        div_int  = '0;
        div_frac = '0;
        repeat (3) @(negedge clk);
        chk("reset_active", int'(div_active), DEF_DIV << NB_FRAC);
        chk("reset_pending", int'(pending), 0);
        chk("reset_tick", int'(tick), 0);

        // Reset wins over a simultaneous load and enable.
        enable   = 1'b1;
        load     = 1'b1;
        div_int  = 16'd7;
        @(negedge clk);
        load = 1'b0;
        chk("reset_beats_load_pending", int'(pending), 0);
        chk("reset_beats_load_active", int'(div_active), DEF_DIV << NB_FRAC);

        // Default divisor: first tick 163 cycles after release, bit tick at 2608.
        reset = 1'b0;
        wait_tick(400, "first_tick", n);
        chk("first_tick_latency", n, 163);
        $display("first o_tick after %0d cycles", n);
        wait_bit(3000, "first_bit", n2);
        chk("first_bit_tick_latency", n + n2, 2608);
        $display("first o_bit_tick after %0d cycles", n + n2);
        wait_tick(400, "period_163", n);
        chk("default_period", n, 163);

        // Mid-period load of int=4: held pending until the 163-cycle period ends.
        repeat (50) @(negedge clk);
        do_load(4, 0);
        chk("midload_pending", int'(pending), 1);
        wait_tick(400, "midload_apply", n);
        chk("midload_apply_wait", n, 163 - 51);
        chk("midload_pending_clear", int'(pending), 0);
        chk("midload_active", int'(div_active), 4 << NB_FRAC);
        wait_tick(20, "div4_a", n);
        chk("div4_period_a", n, 4);
        wait_tick(20, "div4_b", n);
        chk("div4_period_b", n, 4);

        // int=10, frac=8: periods 10,10,11,10,11,... ; 32 periods after the first sum to 336.
        do_load(10, 8);
        wait_tick(20, "f8_apply", n);
        chk("f8_active", int'(div_active), (10 << NB_FRAC) | 8);
        for (int i = 1; i <= 33; i++) wait_tick(40, "f8_period", per[i]);
        chk("f8_p1", per[1], 10);
        chk("f8_p2", per[2], 10);
        chk("f8_p3", per[3], 11);
        sum = 0;
        for (int i = 2; i <= 33; i++) sum += per[i];
        chk("f8_sum32", sum, 336);
        $display("frac=8: 32-period total %0d", sum);

        // int=10, frac=1: one 11-cycle period in each 16.
        do_load(10, 1);
        wait_tick(40, "f1_apply", n);
        for (int i = 1; i <= 17; i++) wait_tick(40, "f1_period", per[i]);
        sum   = 0;
        cnt11 = 0;
        for (int i = 2; i <= 17; i++) begin
            sum += per[i];
            if (per[i] == 11) cnt11++;
        end
        chk("f1_count11", cnt11, 1);
        chk("f1_sum16", sum, 161);
        $display("frac=1: %0d long periods, 16-period total %0d", cnt11, sum);

        // Divisor 0 acts as 1: continuous tick.
        do_load(0, 0);
        wait_tick(40, "d1_apply", n);
        ticks_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tick) ticks_seen++;
        end
        chk("d1_continuous", ticks_seen, 20);

        // Pause for 50 cycles at cnt=100; next tick 63 enabled cycles later.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (100) @(negedge clk);
        enable     = 1'b0;
        ticks_seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (tick) ticks_seen++;
        end
        chk("pause_no_ticks", ticks_seen, 0);
        enable = 1'b1;
        wait_tick(200, "resume", n);
        chk("resume_latency", n, 63);
        $display("resume: o_tick after %0d enabled cycles", n);

        // Two loads before a wrap: last one wins.
        do_load(20, 0);
        do_load(30, 0);
        wait_tick(400, "lastwins_apply", n);
        chk("lastwins_active", int'(div_active), 30 << NB_FRAC);
        wait_tick(40, "div30", n);
        chk("div30_period", n, 30);

        // Reset with a load pending discards it.
        do_load(50, 0);
        chk("pend_before_reset", int'(pending), 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("pend_after_reset", int'(pending), 0);
        chk("active_after_reset", int'(div_active), DEF_DIV << NB_FRAC);

        // Randomised traffic checked by the model every cycle.
        for (int i = 0; i < 4000; i++) begin
            reset    = ($urandom_range(0, 299) == 0);
            enable   = ($urandom_range(0, 7) != 0);
            load     = ($urandom_range(0, 39) == 0);
            div_int  = NB_DIV'($urandom_range(0, 12));
            div_frac = NB_FRAC'($urandom);
            if (load) $display("random load int=%0d frac=%0d enable=%0d reset=%0d at cycle %0d",
                               div_int, div_frac, enable, reset, cyc);
            @(negedge clk);
        end
        reset  = 1'b0;
        load   = 1'b0;
        enable = 1'b1;
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/baud_gen_prog.md
BAUD_GEN_PROG -- requirements
Module: baud_gen_prog

Interface
REQ-001 Parameter NB_DIV, default 16: width of the integer divisor.
REQ-002 Parameter NB_FRAC, default 4: width of the fractional divisor, in units of 1/2^NB_FRAC cycle.
REQ-003 Parameter OVERSAMPLE, default 16: sample ticks per bit tick, legal range 2..256.
REQ-004 Parameter DEFAULT_DIV, default 163: integer divisor loaded at reset.
REQ-005 Parameter DEFAULT_FRAC, default 0: fractional divisor loaded at reset.
REQ-006 Port clk, input, 1 bit: clock; all state updates on its rising edge.
REQ-007 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 Port i_enable, input, 1 bit: high = counting; low = all counters hold.
REQ-009 Port i_div_int, input, NB_DIV bits: new integer divisor, sampled when i_load is high.
REQ-010 Port i_div_frac, input, NB_FRAC bits: new fractional divisor, sampled when i_load is high.
REQ-011 Port i_load, input, 1 bit: one-cycle strobe that captures the new divisor into a pending register.
REQ-012 Port o_tick, output, 1 bit: registered one-cycle pulse at the oversample rate.
REQ-013 Port o_bit_tick, output, 1 bit: registered one-cycle pulse, once per OVERSAMPLE o_tick pulses.
REQ-014 Port o_pending, output, 1 bit: a loaded divisor is waiting to become active.
REQ-015 Port o_div_active, output, NB_DIV+NB_FRAC bits: active divisor as {int, frac}.

Function
REQ-016 Internal state: main counter cnt, fraction accumulator acc (NB_FRAC bits), period-extend flag ext, sub-counter sub (0..OVERSAMPLE-1), active divisor, pending divisor, pending flag.
REQ-017 Effective integer divisor D = max(active int, 1); i_div_int of 0 behaves as 1.
REQ-018 Terminal count L = D-1+ext; a cycle is a wrap cycle when i_enable=1 and cnt==L.
REQ-019 Non-wrap cycle with i_enable=1: cnt <= cnt+1.
REQ-020 Wrap cycle: cnt <= 0, {carry, acc} <= acc + active frac (NB_FRAC+1-bit sum), ext <= carry.
REQ-021 Resulting period = D or D+1 cycles; average period = D + frac/2^NB_FRAC cycles.
REQ-022 o_tick is registered: high in the cycle after each wrap cycle, low otherwise.
REQ-023 sub advances by 1 on each wrap cycle and goes from OVERSAMPLE-1 to 0.
REQ-024 o_bit_tick is registered: high in the cycle after a wrap cycle with sub==OVERSAMPLE-1, which is the same cycle as that o_tick.
REQ-025 i_enable=0: cnt, acc, ext and sub hold; no wrap; o_tick and o_bit_tick are 0 from the next cycle; counting resumes from the held state.
REQ-026 i_load=1: pending <= {i_div_int, i_div_frac}, pending flag <= 1; a later i_load before apply overwrites (last write wins).
REQ-027 Apply point: the first wrap cycle with pending flag set, or any cycle with pending flag set and i_enable=0.
REQ-028 At apply: active <= pending, pending flag <= 0, cnt <= 0, acc <= 0, ext <= 0; sub is unchanged, so bit phase is preserved.
REQ-029 i_load in the same cycle as an apply point: the new value goes to pending and is applied at the next apply point, not the current one; the pending flag stays 1.
REQ-030 Divisor D=1 with frac=0: o_tick is continuously high while enabled, after the first-cycle latency.
REQ-031 o_pending mirrors the pending flag; o_div_active mirrors the active register.

Reset
REQ-032 On reset: active = {DEFAULT_DIV, DEFAULT_FRAC}; cnt, acc, ext, sub, pending register and pending flag = 0; o_tick = 0; o_bit_tick = 0.
REQ-033 Reset overrides i_load and i_enable in the same cycle.
REQ-034 Reset asserted mid-period or with a load pending discards all progress and the pending value.
REQ-035 After reset release with i_enable=1, the first o_tick occurs exactly D+ext cycles later, where ext=0.

Verification
REQ-036 Defaults, i_enable=1 from reset release -> o_tick every 163 cycles, first at cycle 163; o_bit_tick every 2608 cycles, coinciding with every 16th o_tick.
REQ-037 Load int=10, frac=8 -> after apply, periods are 10,10,11,10,11,...; any 32 consecutive periods total 336 cycles.
REQ-038 Load int=10, frac=1 -> exactly one period of 11 and fifteen periods of 10 in every 16 periods.
REQ-039 i_load mid-period, int=4 -> o_pending=1 until the current 163-cycle period wraps; then o_pending=0, o_div_active updates, ticks every 4 cycles, o_bit_tick phase continuous.
REQ-040 i_enable low for 50 cycles at cnt=100 -> no ticks during the gap; the next o_tick arrives 63 enabled cycles after re-enable.
REQ-041 Two i_load strobes (int=20, then int=30) before a wrap, and reset while a load is pending -> 30 becomes active and 20 never appears; after reset, o_pending=0 and the active divisor is 163.
